// File: rtl/cpu_pkg.sv
// Shared types for the CPU memory subsystem: response-FSM states and arbiter defaults.
package cpu_pkg;

  localparam int STARVE_MAX_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_RSP = 2'd1,
    DM_RSP = 2'd2
  } rsp_state_e;

  // Bits needed to hold 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating counter of consecutive DM wins while IF waits; clear has priority over increment.
// Latency: count visible the cycle after inc/clr; no backpressure.
module mem_arb_starve_cnt
  import cpu_pkg::*;
#(
  parameter  int MAX   = STARVE_MAX_DEFAULT,
  localparam int CNT_W = cnt_width(MAX)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_W'(MAX))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and data memory; DM has priority with IF anti-starvation.
// Latency: combinational grant, read data exactly one cycle later; losers stall and hold their request.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic              dm_web,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_bweb,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_ceb,
  output logic              mem_web,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic [DATA_W-1:0] mem_bweb,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              stall
);

  localparam int CNT_W = cnt_width(STARVE_MAX);

  rsp_state_e       state_q;
  rsp_state_e       state_d;
  logic [CNT_W-1:0] starve_cnt;
  logic             starve_sat;
  logic             if_gnt_c;
  logic             dm_gnt_c;

  assign starve_sat = (starve_cnt == CNT_W'(STARVE_MAX));

  // Grants are masked while reset is held so the SRAM stays idle and stall reads 0.
  always_comb begin
    if_gnt_c = 1'b0;
    dm_gnt_c = 1'b0;
    if (rst) begin
      if (if_req && (!dm_req || starve_sat)) begin
        if_gnt_c = 1'b1;
      end else if (dm_req) begin
        dm_gnt_c = 1'b1;
      end
    end
  end

  assign if_gnt = if_gnt_c;
  assign dm_gnt = dm_gnt_c;
  assign stall  = rst & ((if_req & ~if_gnt_c) | (dm_req & ~dm_gnt_c));

  mem_arb_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .inc_i  (dm_gnt_c & if_req),
    .clr_i  (if_gnt_c | ~if_req),
    .cnt_o  (starve_cnt)
  );

  always_comb begin
    mem_ceb  = 1'b1;
    mem_web  = 1'b1;
    mem_addr = '0;
    mem_din  = '0;
    mem_bweb = '1;
    if (if_gnt_c) begin
      mem_ceb  = 1'b0;
      mem_addr = if_addr;
    end else if (dm_gnt_c) begin
      mem_ceb  = 1'b0;
      mem_web  = dm_web;
      mem_addr = dm_addr;
      mem_din  = dm_wdata;
      mem_bweb = dm_bweb;
    end
  end

  // Stores return nothing, so only a DM read arms the DM response state.
  always_comb begin
    state_d = IDLE;
    if (if_gnt_c) begin
      state_d = IF_RSP;
    end else if (dm_gnt_c && dm_web) begin
      state_d = DM_RSP;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = '0;
    dm_rvalid = 1'b0;
    dm_rdata  = '0;
    case (state_q)
      IF_RSP: begin
        if_rvalid = 1'b1;
        if_rdata  = mem_dout;
      end
      DM_RSP: begin
        dm_rvalid = 1'b1;
        dm_rdata  = mem_dout;
      end
      default: begin
        if_rvalid = 1'b0;
        dm_rvalid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural one-cycle-latency SRAM.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [13:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic [13:0] dm_addr;
  logic        dm_web;
  logic [31:0] dm_wdata;
  logic [31:0] dm_bweb;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_ceb;
  logic        mem_web;
  logic [13:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_bweb;
  logic [31:0] mem_dout;
  logic        stall;

  int n_cmp;
  int n_err;

  logic [31:0] sram [0:16383];

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_addr   (dm_addr),
    .dm_web    (dm_web),
    .dm_wdata  (dm_wdata),
    .dm_bweb   (dm_bweb),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .mem_ceb   (mem_ceb),
    .mem_web   (mem_web),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_bweb  (mem_bweb),
    .mem_dout  (mem_dout),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-masked write (bweb=0 writes the bit); read data appears the cycle after the access.
  always @(posedge clk) begin
    if (!mem_ceb) begin
      if (!mem_web) begin
        sram[mem_addr] <= (sram[mem_addr] & mem_bweb) | (mem_din & ~mem_bweb);
      end
      mem_dout <= sram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req   = 1'b0;
    if_addr  = '0;
    dm_req   = 1'b0;
    dm_addr  = '0;
    dm_web   = 1'b1;
    dm_wdata = '0;
    dm_bweb  = '1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".if_gnt"},    64'(if_gnt),    64'h0);
    chk({tag, ".dm_gnt"},    64'(dm_gnt),    64'h0);
    chk({tag, ".if_rvalid"}, 64'(if_rvalid), 64'h0);
    chk({tag, ".dm_rvalid"}, 64'(dm_rvalid), 64'h0);
    chk({tag, ".if_rdata"},  64'(if_rdata),  64'h0);
    chk({tag, ".dm_rdata"},  64'(dm_rdata),  64'h0);
    chk({tag, ".mem_ceb"},   64'(mem_ceb),   64'h1);
    chk({tag, ".mem_web"},   64'(mem_web),   64'h1);
    chk({tag, ".mem_bweb"},  64'(mem_bweb),  64'hFFFF_FFFF);
    chk({tag, ".mem_addr"},  64'(mem_addr),  64'h0);
    chk({tag, ".mem_din"},   64'(mem_din),   64'h0);
    chk({tag, ".stall"},     64'(stall),     64'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int a = 0; a < 16384; a++) sram[a] = 32'h0;
    sram[14'h0010] = 32'h0000_0013;
    sram[14'h0014] = 32'h0000_0093;
    sram[14'h0200] = 32'hA5A5_0200;
    sram[14'h0040] = 32'h1234_0000;

    // Reset with live requests and a pending store: everything must stay quiet.
    rst = 1'b0;
    idle_inputs();
    if_req   = 1'b1;
    if_addr  = 14'h0010;
    dm_req   = 1'b1;
    dm_web   = 1'b0;
    dm_addr  = 14'h0123;
    dm_wdata = 32'hCAFE_F00D;
    dm_bweb  = 32'h0;
    #3;
    chk_reset_outputs("rst");
    cyc();
    cyc();
    rst = 1'b1;
    idle_inputs();
    #2;
    chk("idle.mem_ceb", 64'(mem_ceb), 64'h1);
    chk("idle.stall",   64'(stall),   64'h0);

    // IF only.
    cyc();
    if_req  = 1'b1;
    if_addr = 14'h0010;
    #2;
    chk("if1.if_gnt",   64'(if_gnt),   64'h1);
    chk("if1.dm_gnt",   64'(dm_gnt),   64'h0);
    chk("if1.stall",    64'(stall),    64'h0);
    chk("if1.mem_ceb",  64'(mem_ceb),  64'h0);
    chk("if1.mem_web",  64'(mem_web),  64'h1);
    chk("if1.mem_addr", 64'(mem_addr), 64'h10);
    chk("if1.mem_bweb", 64'(mem_bweb), 64'hFFFF_FFFF);
    cyc();
    idle_inputs();
    #2;
    chk("if1.if_rvalid", 64'(if_rvalid), 64'h1);
    chk("if1.if_rdata",  64'(if_rdata),  64'h13);
    chk("if1.dm_rvalid", 64'(dm_rvalid), 64'h0);

    // IF and DM read collide: DM first, IF next cycle alongside DM response.
    cyc();
    if_req  = 1'b1;
    if_addr = 14'h0014;
    dm_req  = 1'b1;
    dm_web  = 1'b1;
    dm_addr = 14'h0200;
    #2;
    chk("col.dm_gnt",   64'(dm_gnt),   64'h1);
    chk("col.if_gnt",   64'(if_gnt),   64'h0);
    chk("col.stall",    64'(stall),    64'h1);
    chk("col.mem_addr", 64'(mem_addr), 64'h200);
    cyc();
    dm_req = 1'b0;
    #2;
    chk("col.dm_rvalid", 64'(dm_rvalid), 64'h1);
    chk("col.dm_rdata",  64'(dm_rdata),  64'hA5A5_0200);
    chk("col.if_gnt",    64'(if_gnt),    64'h1);
    chk("col.stall2",    64'(stall),     64'h0);
    chk("col.mem_addr2", 64'(mem_addr),  64'h14);
    cyc();
    idle_inputs();
    #2;
    chk("col.if_rvalid", 64'(if_rvalid), 64'h1);
    chk("col.if_rdata",  64'(if_rdata),  64'h93);
    chk("col.dm_rvalid2", 64'(dm_rvalid), 64'h0);

    // Masked store of the low half, then read back.
    cyc();
    dm_req   = 1'b1;
    dm_web   = 1'b0;
    dm_addr  = 14'h0040;
    dm_wdata = 32'hDEAD_BEEF;
    dm_bweb  = 32'hFFFF_0000;
    #2;
    chk("st.dm_gnt",   64'(dm_gnt),   64'h1);
    chk("st.mem_web",  64'(mem_web),  64'h0);
    chk("st.mem_bweb", 64'(mem_bweb), 64'hFFFF_0000);
    chk("st.mem_din",  64'(mem_din),  64'hDEAD_BEEF);
    cyc();
    idle_inputs();
    #2;
    chk("st.dm_rvalid", 64'(dm_rvalid), 64'h0);
    cyc();
    dm_req  = 1'b1;
    dm_web  = 1'b1;
    dm_addr = 14'h0040;
    #2;
    chk("ld.dm_gnt", 64'(dm_gnt), 64'h1);
    cyc();
    idle_inputs();
    #2;
    chk("ld.dm_rvalid", 64'(dm_rvalid), 64'h1);
    chk("ld.dm_rdata",  64'(dm_rdata),  64'h1234_BEEF);

    // Both held for 6 cycles: DM x4, IF, DM; responses trail by one cycle.
    for (int i = 0; i < 6; i++) begin
      cyc();
      if_req  = 1'b1;
      if_addr = 14'h0010;
      dm_req  = 1'b1;
      dm_web  = 1'b1;
      dm_addr = 14'h0200;
      #2;
      chk($sformatf("starve%0d.if_gnt", i), 64'(if_gnt), 64'(i == 4));
      chk($sformatf("starve%0d.dm_gnt", i), 64'(dm_gnt), 64'(i != 4));
      if (i > 0) begin
        chk($sformatf("starve%0d.if_rvalid", i), 64'(if_rvalid), 64'(i == 5));
        chk($sformatf("starve%0d.dm_rvalid", i), 64'(dm_rvalid), 64'(i != 5));
      end
    end
    cyc();
    idle_inputs();
    #2;
    chk("starve.tail_dm_rvalid", 64'(dm_rvalid), 64'h1);

    // Dropping if_req for a cycle restarts the starvation count.
    for (int j = 0; j < 9; j++) begin
      cyc();
      if_req  = (j != 3);
      if_addr = 14'h0010;
      dm_req  = 1'b1;
      dm_web  = 1'b1;
      dm_addr = 14'h0200;
      #2;
      chk($sformatf("clr%0d.if_gnt", j), 64'(if_gnt), 64'(j == 8));
    end
    cyc();
    idle_inputs();
    #2;

    // Reset the cycle after an IF grant: response must vanish.
    cyc();
    if_req  = 1'b1;
    if_addr = 14'h0010;
    #2;
    chk("rst2.if_gnt", 64'(if_gnt), 64'h1);
    cyc();
    rst = 1'b0;
    #2;
    chk_reset_outputs("rst2.held");
    cyc();
    if_req = 1'b0;
    #2;
    chk("rst2.if_rvalid_hold", 64'(if_rvalid), 64'h0);
    cyc();
    rst = 1'b1;
    #2;
    chk("rst2.if_rvalid_rel", 64'(if_rvalid), 64'h0);
    cyc();
    #2;
    chk("rst2.if_rvalid_post", 64'(if_rvalid), 64'h0);
    chk("rst2.mem_ceb_post",   64'(mem_ceb),   64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 14, word address width; DATA_W, 32, data width; STARVE_MAX, 4, max consecutive DM grants while IF is waiting.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be as listed below.
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- if_req  in  1  instruction fetch request.
- if_addr  in  ADDR_W  fetch word address.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  fetch data valid.
- if_rdata  out  DATA_W  fetch data.
- dm_req  in  1  data request.
- dm_addr  in  ADDR_W  data word address.
- dm_web  in  1  write enable, active-low; 1 means read.
- dm_wdata  in  DATA_W  store data.
- dm_bweb  in  DATA_W  bit write mask, active-low.
- dm_gnt  out  1  data request accepted this cycle.
- dm_rvalid  out  1  load data valid.
- dm_rdata  out  DATA_W  load data.
- mem_ceb  out  1  SRAM chip enable, active-low.
- mem_web  out  1  SRAM write enable, active-low.
- mem_addr  out  ADDR_W  SRAM address.
- mem_din  out  DATA_W  SRAM write data.
- mem_bweb  out  DATA_W  SRAM bit mask, active-low.
- mem_dout  in  DATA_W  SRAM read data, valid one cycle after the access.
- stall  out  1  pipeline stall, equal to (if_req & ~if_gnt) | (dm_req & ~dm_gnt).

Function
REQ-004 The arbiter SHALL grant at most one requester per cycle; the grant SHALL be combinational from the current-cycle requests and state.
REQ-005 Priority SHALL be: DM wins when starve_cnt < STARVE_MAX; IF wins when starve_cnt == STARVE_MAX and if_req=1.
REQ-006 starve_cnt SHALL increment, saturating at STARVE_MAX, when dm_gnt=1 and if_req=1; it SHALL clear on if_gnt=1 or when if_req=0.
REQ-007 On a grant, mem_ceb=0 and mem_addr SHALL come from the winner. For IF, mem_web=1 and mem_bweb=all-ones. For DM, mem_web, mem_din and mem_bweb SHALL come from dm_web, dm_wdata and dm_bweb.
REQ-008 With no grant: mem_ceb=1, mem_web=1, mem_bweb=all-ones, mem_addr=0, mem_din=0.
REQ-009 The response FSM SHALL have states IDLE, IF_RSP and DM_RSP.
- Next state IF_RSP after if_gnt.
- Next state DM_RSP after a dm_gnt with dm_web=1.
- Otherwise next state IDLE; a DM write SHALL produce no response.
REQ-010 In IF_RSP: if_rvalid=1 and if_rdata=mem_dout. In DM_RSP: dm_rvalid=1 and dm_rdata=mem_dout. Otherwise the rvalid signals are 0 and the rdata signals are 0.
REQ-011 Read latency SHALL be exactly 1 cycle from grant to rvalid. A new grant MAY occur in the same cycle a response is returned, giving back-to-back throughput of one access per cycle.
REQ-012 A requester SHALL hold req and its payload stable until granted. The arbiter SHALL NOT latch a request that was not granted.
REQ-013 If both requesters are idle, the FSM SHALL go to IDLE and starve_cnt SHALL clear.

Reset
REQ-014 While rst=0, the FSM SHALL be IDLE and starve_cnt=0.
REQ-015 While rst=0, outputs SHALL be: gnt=0, rvalid=0, rdata=0, mem_ceb=1, mem_web=1, mem_bweb=all-ones, mem_addr=0, mem_din=0, stall=0.
REQ-016 Reset asserted mid-access SHALL drop the pending response; no rvalid SHALL be issued for it after reset release.

Structure
REQ-017 The response-state enum and STARVE_MAX default SHALL live in shared package cpu_pkg.
REQ-018 One sub-module SHALL be used: mem_arb_starve_cnt, a saturating counter with inc and clr inputs.

Verification
REQ-019 IF only, if_addr=0x0010, SRAM word 0x00000013 -> if_gnt=1 in cycle 0; if_rvalid=1 and if_rdata=0x00000013 in cycle 1; stall=0.
REQ-020 IF and DM read in the same cycle (dm_addr=0x0200) -> dm_gnt=1, if_gnt=0, stall=1; the next cycle gives dm_rvalid=1 and if_gnt=1.
REQ-021 DM store: dm_web=0, dm_addr=0x0040, dm_wdata=0xDEADBEEF, dm_bweb=0xFFFF0000 -> mem_web=0 and mem_bweb=0xFFFF0000; no dm_rvalid; a later read of 0x0040 returns the low half 0xBEEF.
REQ-022 dm_req held high for 6 cycles with if_req high -> DM granted in cycles 0-3, IF granted in cycle 4, DM granted in cycle 5.
REQ-023 rst driven low in the cycle after if_gnt -> if_rvalid=0 during reset and after release; all outputs at their reset values.
